debug_regfile_reader: RTL

//   Debug-side reader of the register-file debug port exposed by the decode stage.
//   On a start request it freezes register-file writes via Debug_on and walks

---
 rtl/debug_regfile_reader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/debug_regfile_reader.sv
// Debug-side reader that freezes the register file, walks every register through the
// decode-stage debug read port and streams each word MSB-byte-first over valid/ready.
module debug_regfile_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              Debug_on,
  output logic [ADDR_W-1:0] Debug_read_reg,
  input  logic [DATA_W-1:0] out_regDebug,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q,   state_d;
  logic [ADDR_W-1:0] index_q,   index_d;
  logic [CNT_W-1:0]  byteCnt_q, byteCnt_d;
  logic [DATA_W-1:0] shreg_q,   shreg_d;
  logic              debugOn_q, debugOn_d;
  logic              txValid_q, txValid_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              handshake;

  assign handshake = txValid_q && tx_ready;

  // The termination check precedes the index increment, so the index never wraps.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    byteCnt_d = byteCnt_q;
    shreg_d   = shreg_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT;
          index_d = '0;
        end
      end
      S_WAIT: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        shreg_d   = out_regDebug;
        byteCnt_d = '0;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (handshake) begin
          shreg_d = shreg_q << 8;
          if (byteCnt_q == LAST_BYTE) begin
            byteCnt_d = '0;
            if (index_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              index_d = index_q + ADDR_W'(1);
              state_d = S_WAIT;
            end
          end else begin
            byteCnt_d = byteCnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they leave the design as flops.
  always_comb begin
    debugOn_d = (state_d == S_WAIT) || (state_d == S_LATCH) || (state_d == S_SEND);
    txValid_d = (state_d == S_SEND);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      index_q   <= '0;
      byteCnt_q <= '0;
      shreg_q   <= '0;
      debugOn_q <= 1'b0;
      txValid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      byteCnt_q <= byteCnt_d;
      shreg_q   <= shreg_d;
      debugOn_q <= debugOn_d;
      txValid_q <= txValid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Debug_on       = debugOn_q;
  assign Debug_read_reg = index_q;
  assign tx_data        = shreg_q[DATA_W-1 -: 8];
  assign tx_valid       = txValid_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
